// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the write-back producer, issue/decode and register-file-side signals
// of the write-back arbiter into one interface.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  localparam int NREG = 2 ** ADDR_W;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_ready;

  logic [ADDR_W-1:0] rd_a1;
  logic [ADDR_W-1:0] rd_a2;
  logic              use_a1;
  logic              use_a2;
  logic              hazard;

  logic              regWrite;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic [NREG-1:0]   busy;
  logic              pc_wr_err;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           iss_valid, iss_rd, rd_a1, rd_a2, use_a1, use_a2,
    output alu_ready, mem_ready, iss_ready, hazard,
           regWrite, A3, WD3, busy, pc_wr_err
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           iss_valid, iss_rd, rd_a1, rd_a2, use_a1, use_a2,
    input  alu_ready, mem_ready, iss_ready, hazard,
           regWrite, A3, WD3, busy, pc_wr_err
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, plus a busy
// scoreboard that stalls WAW issue and flags read hazards to decode.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int PC_REG = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  logic              last_grant_q, last_grant_d;
  logic              reg_write_q,  reg_write_d;
  logic [ADDR_W-1:0] a3_q,         a3_d;
  logic [DATA_W-1:0] wd3_q,        wd3_d;
  logic [NREG-1:0]   busy_q,       busy_d;
  logic              pc_err_q,     pc_err_d;

  logic              grant_alu, grant_mem, grant_any;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              sel_is_pc;
  logic              iss_ready;

  // ALU wins contention unless it was the most recent grantee.
  assign grant_alu = bus.alu_valid & (~bus.mem_valid | (last_grant_q == GNT_MEM));
  assign grant_mem = bus.mem_valid & ~grant_alu;
  assign grant_any = grant_alu | grant_mem;

  assign sel_rd    = grant_alu ? bus.alu_rd   : bus.mem_rd;
  assign sel_data  = grant_alu ? bus.alu_data : bus.mem_data;
  assign sel_is_pc = (sel_rd == PC_ADDR);

  assign iss_ready = ~busy_q[bus.iss_rd] | (bus.iss_rd == PC_ADDR);

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;
  assign bus.iss_ready = iss_ready;
  assign bus.hazard    = (bus.use_a1 & busy_q[bus.rd_a1]) |
                         (bus.use_a2 & busy_q[bus.rd_a2]);

  assign bus.regWrite  = reg_write_q;
  assign bus.A3        = a3_q;
  assign bus.WD3       = wd3_q;
  assign bus.busy      = busy_q;
  assign bus.pc_wr_err = pc_err_q;

  always_comb begin
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    a3_d         = a3_q;
    wd3_d        = wd3_q;
    pc_err_d     = 1'b0;
    if (grant_any) begin
      last_grant_d = grant_mem ? GNT_MEM : GNT_ALU;
      pc_err_d     = sel_is_pc;
      // PC writes are consumed but never reach the file.
      if (!sel_is_pc) begin
        reg_write_d = 1'b1;
        a3_d        = sel_rd;
        wd3_d       = sel_data;
      end
    end
  end

  // Clear first so that a same-edge issue to the retiring register wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q)
      busy_d[a3_q] = 1'b0;
    if (bus.iss_valid && iss_ready && (bus.iss_rd != PC_ADDR))
      busy_d[bus.iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= GNT_MEM;
      reg_write_q  <= 1'b0;
      a3_q         <= '0;
      wd3_q        <= '0;
      busy_q       <= '0;
      pc_err_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      a3_q         <= a3_d;
      wd3_q        <= wd3_d;
      busy_q       <= busy_d;
      pc_err_q     <= pc_err_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter: arbitration, write latency,
// PC-register drop, scoreboard set/clear and reset abort.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  regfile_wb_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .PC_REG(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next active edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.rd_a1 = '0; bus.rd_a2 = '0; bus.use_a1 = 1'b0; bus.use_a2 = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle_inputs();
    rst = 1'b0;
    step(); step();

    check("rst_regWrite", 32'(bus.regWrite), 32'd0);
    check("rst_A3", 32'(bus.A3), 32'd0);
    check("rst_WD3", 32'(bus.WD3), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pc_err", 32'(bus.pc_wr_err), 32'd0);
    check("rst_iss_ready", 32'(bus.iss_ready), 32'd1);
    rst = 1'b1;
    step();

    // Single ALU write
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd3; bus.alu_data = 16'h1234;
    #1;
    check("t1_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("t1_mem_ready", 32'(bus.mem_ready), 32'd0);
    step();
    bus.alu_valid = 1'b0;
    check("t1_regWrite", 32'(bus.regWrite), 32'd1);
    check("t1_A3", 32'(bus.A3), 32'd3);
    check("t1_WD3", 32'(bus.WD3), 32'h1234);
    step();
    check("t1_regWrite_off", 32'(bus.regWrite), 32'd0);
    check("t1_A3_hold", 32'(bus.A3), 32'd3);
    check("t1_WD3_hold", 32'(bus.WD3), 32'h1234);

    // Fresh reset so contention starts with ALU
    rst = 1'b0; step(); rst = 1'b1;

    bus.alu_valid = 1'b1; bus.alu_rd = 4'd1; bus.alu_data = 16'hAAAA;
    bus.mem_valid = 1'b1; bus.mem_rd = 4'd2; bus.mem_data = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_alu_ready", 32'(bus.alu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_mem_ready", 32'(bus.mem_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_not_both", 32'(bus.alu_ready & bus.mem_ready), 32'd0);
      step();
      check("rr_regWrite", 32'(bus.regWrite), 32'd1);
      check("rr_A3", 32'(bus.A3), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("rr_WD3", 32'(bus.WD3), (i % 2 == 0) ? 32'hAAAA : 32'h5555);
    end
    idle_inputs();
    step();
    check("rr_idle_regWrite", 32'(bus.regWrite), 32'd0);

    // Scoreboard: issue to 5, hazard, WAW stall, retire via load
    bus.iss_valid = 1'b1; bus.iss_rd = 4'd5;
    #1;
    check("sb_iss_ready_free", 32'(bus.iss_ready), 32'd1);
    step();
    bus.iss_valid = 1'b0;
    check("sb_busy_set", 32'(bus.busy), 32'h0020);
    bus.rd_a1 = 4'd5; bus.use_a1 = 1'b0;
    #1;
    check("sb_hazard_unused", 32'(bus.hazard), 32'd0);
    bus.use_a1 = 1'b1;
    #1;
    check("sb_hazard_a1", 32'(bus.hazard), 32'd1);
    bus.use_a1 = 1'b0; bus.rd_a2 = 4'd5; bus.use_a2 = 1'b1;
    #1;
    check("sb_hazard_a2", 32'(bus.hazard), 32'd1);
    bus.rd_a2 = 4'd4;
    #1;
    check("sb_hazard_a2_free", 32'(bus.hazard), 32'd0);
    bus.rd_a2 = 4'd5;
    bus.iss_rd = 4'd5;
    #1;
    check("sb_waw_stall", 32'(bus.iss_ready), 32'd0);
    bus.mem_valid = 1'b1; bus.mem_rd = 4'd5; bus.mem_data = 16'hBEEF;
    #1;
    check("sb_mem_ready", 32'(bus.mem_ready), 32'd1);
    step();
    bus.mem_valid = 1'b0;
    check("sb_wr_regWrite", 32'(bus.regWrite), 32'd1);
    check("sb_wr_A3", 32'(bus.A3), 32'd5);
    check("sb_busy_pending", 32'(bus.busy), 32'h0020);
    check("sb_hazard_pending", 32'(bus.hazard), 32'd1);
    step();
    check("sb_busy_clear", 32'(bus.busy), 32'h0000);
    check("sb_hazard_clear", 32'(bus.hazard), 32'd0);
    check("sb_iss_ready_clear", 32'(bus.iss_ready), 32'd1);
    idle_inputs();

    // Write to PC register is dropped and flagged
    bus.mem_valid = 1'b1; bus.mem_rd = 4'd15; bus.mem_data = 16'hFFFF;
    #1;
    check("pc_mem_ready", 32'(bus.mem_ready), 32'd1);
    step();
    bus.mem_valid = 1'b0;
    check("pc_regWrite", 32'(bus.regWrite), 32'd0);
    check("pc_err_pulse", 32'(bus.pc_wr_err), 32'd1);
    check("pc_busy", 32'(bus.busy), 32'h0000);
    step();
    check("pc_err_one_cycle", 32'(bus.pc_wr_err), 32'd0);
    bus.iss_valid = 1'b1; bus.iss_rd = 4'd15;
    bus.rd_a1 = 4'd15; bus.use_a1 = 1'b1;
    #1;
    check("pc_iss_ready", 32'(bus.iss_ready), 32'd1);
    step();
    bus.iss_valid = 1'b0;
    check("pc_iss_no_busy", 32'(bus.busy), 32'h0000);
    check("pc_no_hazard", 32'(bus.hazard), 32'd0);
    idle_inputs();

    // Reset during the grant cycle aborts the write and the scoreboard
    bus.iss_valid = 1'b1; bus.iss_rd = 4'd7;
    step();
    bus.iss_valid = 1'b0;
    check("ra_busy7", 32'(bus.busy), 32'h0080);
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd7; bus.alu_data = 16'h7777;
    #1;
    check("ra_alu_ready", 32'(bus.alu_ready), 32'd1);
    rst = 1'b0;
    step();
    bus.alu_valid = 1'b0;
    check("ra_regWrite", 32'(bus.regWrite), 32'd0);
    check("ra_busy", 32'(bus.busy), 32'h0000);
    check("ra_pc_err", 32'(bus.pc_wr_err), 32'd0);
    rst = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd1; bus.alu_data = 16'h0101;
    bus.mem_valid = 1'b1; bus.mem_rd = 4'd2; bus.mem_data = 16'h0202;
    #1;
    check("ra_first_alu", 32'(bus.alu_ready), 32'd1);
    check("ra_first_mem", 32'(bus.mem_ready), 32'd0);
    step();
    idle_inputs();
    step();

    // Same-edge issue and retire on register 9: set wins
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd9; bus.alu_data = 16'h0909;
    #1;
    check("sw_alu_ready", 32'(bus.alu_ready), 32'd1);
    step();
    bus.alu_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = 4'd9;
    #1;
    check("sw_retire_regWrite", 32'(bus.regWrite), 32'd1);
    check("sw_retire_A3", 32'(bus.A3), 32'd9);
    check("sw_iss_ready", 32'(bus.iss_ready), 32'd1);
    step();
    bus.iss_valid = 1'b0;
    check("sw_busy9", 32'(bus.busy), 32'h0200);
    check("sw_regWrite_off", 32'(bus.regWrite), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
